input_dev_buffer: RTL and testbench

Buffered input-device front end that feeds the processor's input port. It accepts bytes from an external source through a valid/ready interface and stores them in a small FIFO. It presents each byte on input_bus using the processor's active-low in_dev_hs/in_dev_ack handshake, and reports occupancy, overflow and handshake timeout status for debug.

---
 rtl/input_dev_buffer.sv | 134 +++++++++++++
 tb/tb_input_dev_buffer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/input_dev_buffer.sv
// Input-device front end: byte FIFO fed by valid/ready, drained onto the
// processor's active-low in_dev_hs/in_dev_ack handshake with debug status.
module input_dev_buffer #(
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter int TIMEOUT = 255
) (
  input  logic          g_clk,
  input  logic          g_clr,
  input  logic          src_valid,
  input  logic [7:0]    src_data,
  output logic          src_ready,
  input  logic          in_dev_ack,
  output logic          in_dev_hs,
  output logic [7:0]    input_bus,
  output logic [AW:0]   fifo_count,
  output logic          overflow,
  output logic          ack_timeout,
  output logic [7:0]    bytes_sent
);

  typedef enum logic [1:0] {IDLE, LOAD, PRESENT, RELEASE} state_t;

  localparam logic [AW:0]   L_DEPTH  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   L_CNT1   = (AW+1)'(1);
  localparam logic [AW-1:0] L_PTR1   = AW'(1);
  localparam logic [7:0]    L_TO     = 8'(TIMEOUT);
  localparam logic [7:0]    L_TO_M1  = 8'(TIMEOUT - 1);

  state_t        r_state, w_state_nxt;
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_hs;
  logic [7:0]    r_bus;
  logic          r_ovf, r_tout;
  logic [7:0]    r_sent, r_to_cnt;

  logic          w_push, w_pop, w_load, w_present;

  assign src_ready   = (r_count < L_DEPTH);
  assign w_push      = src_valid && src_ready;
  assign w_present   = (r_state == PRESENT);

  assign in_dev_hs   = r_hs;
  assign input_bus   = r_bus;
  assign fifo_count  = r_count;
  assign overflow    = r_ovf;
  assign ack_timeout = r_tout;
  assign bytes_sent  = r_sent;

  always_ff @(posedge g_clk or posedge g_clr) begin
    if (g_clr) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // The FIFO read happens on the IDLE->LOAD edge so LOAD is the setup cycle
  // with input_bus already stable and in_dev_hs still high.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_count != '0) begin
          w_state_nxt = LOAD;
          w_load      = 1'b1;
        end
      end
      LOAD:    w_state_nxt = PRESENT;
      PRESENT: begin
        if (!in_dev_ack) begin
          w_pop       = 1'b1;
          w_state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        if (in_dev_ack) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= src_data;
  end

  always_ff @(posedge g_clk or posedge g_clr) begin
    if (g_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + L_PTR1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + L_PTR1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + L_CNT1;
        2'b01:   r_count <= r_count - L_CNT1;
        default: r_count <= r_count;
      endcase
      if (src_valid && !src_ready) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge g_clk or posedge g_clr) begin
    if (g_clr) begin
      r_hs   <= 1'b1;
      r_bus  <= 8'h00;
      r_sent <= 8'h00;
    end else begin
      if (w_load)                r_bus <= r_mem[r_rd_ptr];
      if (r_state == LOAD)       r_hs  <= 1'b0;
      if (w_pop) begin
        r_hs   <= 1'b1;
        r_sent <= r_sent + 8'd1;
      end
    end
  end

  // Timeout only flags a slow processor; the handshake keeps waiting.
  always_ff @(posedge g_clk or posedge g_clr) begin
    if (g_clr) begin
      r_to_cnt <= 8'h00;
      r_tout   <= 1'b0;
    end else if (w_pop) begin
      r_to_cnt <= 8'h00;
    end else if (w_present) begin
      if (r_to_cnt < L_TO)     r_to_cnt <= r_to_cnt + 8'd1;
      if (r_to_cnt >= L_TO_M1) r_tout   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_input_dev_buffer.sv
// Directed + randomized bench for input_dev_buffer against a queue-based
// model of the FIFO, delivery order, sticky flags and byte count.
module tb_input_dev_buffer;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int TO    = 4;

  logic          g_clk = 1'b0;
  logic          g_clr;
  logic          src_valid;
  logic [7:0]    src_data;
  logic          src_ready;
  logic          in_dev_ack;
  logic          in_dev_hs;
  logic [7:0]    input_bus;
  logic [AW:0]   fifo_count;
  logic          overflow;
  logic          ack_timeout;
  logic [7:0]    bytes_sent;

  int            n_chk = 0;
  int            n_err = 0;
  logic [7:0]    q[$];
  logic [7:0]    m_sent;
  logic          m_ovf, m_tout;
  int            m_tocnt;

  input_dev_buffer #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TO)) dut (
    .g_clk(g_clk), .g_clr(g_clr),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .in_dev_ack(in_dev_ack), .in_dev_hs(in_dev_hs), .input_bus(input_bus),
    .fifo_count(fifo_count), .overflow(overflow), .ack_timeout(ack_timeout),
    .bytes_sent(bytes_sent)
  );

  always #5 g_clk = ~g_clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkc(input string tag, input logic [AW:0] obs, input logic [AW:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_sent  = 8'h00;
    m_ovf   = 1'b0;
    m_tout  = 1'b0;
    m_tocnt = 0;
  endtask

  // One clock: apply the protocol rules to the inputs held over this cycle,
  // then compare status outputs just after the edge.
  task automatic tick();
    bit push, pop, ovf;
    push = src_valid && (q.size() < DEPTH);
    ovf  = src_valid && (q.size() == DEPTH);
    pop  = (in_dev_hs === 1'b0) && (in_dev_ack === 1'b0);
    if (pop) begin
      chk8("deliver", input_bus, (q.size() > 0) ? q[0] : 8'hxx);
      if (q.size() > 0) void'(q.pop_front());
      m_sent  = m_sent + 8'd1;
      m_tocnt = 0;
    end else if (in_dev_hs === 1'b0) begin
      if (m_tocnt < TO) m_tocnt++;
      if (m_tocnt == TO) m_tout = 1'b1;
    end
    if (push) q.push_back(src_data);
    if (ovf)  m_ovf = 1'b1;
    @(posedge g_clk); #1;
    chkc("fifo_count", fifo_count, (AW+1)'(q.size()));
    chk1("src_ready", src_ready, q.size() < DEPTH);
    chk1("overflow", overflow, m_ovf);
    chk1("ack_timeout", ack_timeout, m_tout);
    chk8("bytes_sent", bytes_sent, m_sent);
  endtask

  task automatic wait_hs_low();
    for (int c = 0; c < 20 && in_dev_hs !== 1'b0; c++) tick();
    chk1("wait_hs_low", in_dev_hs, 1'b0);
  endtask

  initial begin
    int nxt;
    bit pushed;
    g_clr = 1'b1; src_valid = 1'b0; src_data = 8'h00; in_dev_ack = 1'b1;
    model_reset();
    #1;
    chk1("rst_hs", in_dev_hs, 1'b1);
    chkc("rst_count", fifo_count, '0);
    chk8("rst_bus", input_bus, 8'h00);
    chk1("rst_ready", src_ready, 1'b1);
    @(posedge g_clk); #1;
    g_clr = 1'b0;

    // Single byte latency
    src_valid = 1'b1; src_data = 8'h0A; tick();
    src_valid = 1'b0; tick();
    chk8("t2_bus_n1", input_bus, 8'h0A);
    chk1("t2_hs_n1", in_dev_hs, 1'b1);
    tick();
    chk1("t2_hs_n2", in_dev_hs, 1'b0);
    in_dev_ack = 1'b0; tick();
    chk1("t2_hs_after_ack", in_dev_hs, 1'b1);
    in_dev_ack = 1'b1; tick(); tick();

    // Ordering and pointer wrap with a responsive processor
    nxt = 1;
    for (int c = 0; c < 200 && !(nxt > 12 && q.size() == 0 && in_dev_hs === 1'b1); c++) begin
      in_dev_ack = in_dev_hs;
      if (nxt <= 12 && src_ready === 1'b1) begin src_valid = 1'b1; src_data = 8'(nxt); end
      else src_valid = 1'b0;
      pushed = src_valid;
      tick();
      if (pushed) nxt++;
    end
    src_valid = 1'b0; in_dev_ack = 1'b1; tick(); tick();
    chk8("t3_sent", bytes_sent, 8'd13);
    chk1("t3_ovf", overflow, 1'b0);

    // Overflow with a processor that never acks
    for (int i = 0; i < 10; i++) begin
      src_valid = 1'b1; src_data = 8'h0A + 8'(i); tick();
    end
    src_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chkc("t4_count", fifo_count, (AW+1)'(8));
    chk1("t4_ready", src_ready, 1'b0);
    chk1("t4_ovf", overflow, 1'b1);
    chk8("t4_bus", input_bus, 8'h0A);
    chk1("t4_hs", in_dev_hs, 1'b0);
    chk1("t4_tout", ack_timeout, 1'b1);

    // Asynchronous reset in the middle of PRESENT
    #3 g_clr = 1'b1;
    #1;
    chk1("t1_hs", in_dev_hs, 1'b1);
    chkc("t1_count", fifo_count, '0);
    chk8("t1_bus", input_bus, 8'h00);
    chk8("t1_sent", bytes_sent, 8'h00);
    chk1("t1_ovf", overflow, 1'b0);
    chk1("t1_tout", ack_timeout, 1'b0);
    @(posedge g_clk); #1;
    g_clr = 1'b0;
    model_reset();

    // Timeout is sticky but does not abort the transfer
    src_valid = 1'b1; src_data = 8'h55; tick();
    src_valid = 1'b0; tick();
    chk8("t5_bus", input_bus, 8'h55);
    tick();
    chk1("t5_hs", in_dev_hs, 1'b0);
    tick(); tick(); tick();
    chk1("t5_tout_3", ack_timeout, 1'b0);
    tick();
    chk1("t5_tout_4", ack_timeout, 1'b1);
    tick(); tick();
    in_dev_ack = 1'b0; tick();
    chk1("t5_hs_done", in_dev_hs, 1'b1);
    chk8("t5_sent", bytes_sent, 8'd1);
    in_dev_ack = 1'b1; tick(); tick();

    // RELEASE holds until ack returns high
    src_valid = 1'b1; src_data = 8'h61; tick();
    src_data = 8'h62; tick();
    src_valid = 1'b0;
    wait_hs_low();
    chk8("t6_first", input_bus, 8'h61);
    in_dev_ack = 1'b0; tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1("t6_hs_release", in_dev_hs, 1'b1);
    end
    in_dev_ack = 1'b1; tick(); tick(); tick();
    chk1("t6_hs_next", in_dev_hs, 1'b0);
    chk8("t6_second", input_bus, 8'h62);
    in_dev_ack = 1'b0; tick();
    in_dev_ack = 1'b1; tick(); tick();

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      src_valid  = ($urandom_range(0, 3) == 0);
      src_data   = 8'($urandom);
      in_dev_ack = ($urandom_range(0, 2) != 0);
      tick();
    end
    src_valid = 1'b0;
    for (int c = 0; c < 200 && !(q.size() == 0 && in_dev_hs === 1'b1); c++) begin
      in_dev_ack = in_dev_hs;
      tick();
    end
    in_dev_ack = 1'b1; tick(); tick();
    chkc("drain_count", fifo_count, '0);
    chk1("drain_hs", in_dev_hs, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
